// File: rtl/majority_event_counter_if.sv
// Report channel from majority_event_counter to its sink.
// Valid/ready handshake carrying the latest event count.
interface majority_event_counter_if #(
  parameter int CNT_W = 8
);
  logic             rpt_val;
  logic             rpt_rdy;
  logic [CNT_W-1:0] rpt_data;

  modport master (
    output rpt_val,
    output rpt_data,
    input  rpt_rdy
  );

  modport slave (
    input  rpt_val,
    input  rpt_data,
    output rpt_rdy
  );
endinterface

// File: rtl/majority_event_counter.sv
// Debounced majority-event counter with saturating count and report.
// Define MAJ_EVT_WRAP_EN to wrap the count at max instead of saturating.
module majority_event_counter #(
  parameter int CNT_W    = 8,
  parameter int MIN_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_in,
  input  logic             clear,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_pulse,
  output logic             sat,
  majority_event_counter_if.master rpt
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HELD
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       hold_q;
  logic [3:0]       hold_d;
  logic             det_q;
  logic             evt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_set;

`ifdef MAJ_EVT_WRAP_EN
  assign cnt_nxt = evt_count + CNT_W'(1);
  assign sat_set = 1'b0;
`else
  assign cnt_nxt = (evt_count == CNT_MAX) ? evt_count
                 : evt_count + CNT_W'(1);
  assign sat_set = (evt_count == CNT_MAX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q   <= 1'b0;
      state_q <= IDLE;
      hold_q  <= 4'd0;
    end else begin
      det_q   <= det_in;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    evt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (det_q) begin
          if (MIN_HOLD == 1) begin
            state_d = HELD;
            evt     = 1'b1;
          end else begin
            state_d = QUAL;
            hold_d  = 4'd1;
          end
        end
      end
      QUAL: begin
        if (!det_q) begin
          state_d = IDLE;
          hold_d  = 4'd0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          evt     = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      HELD: begin
        if (!det_q) begin
          state_d = IDLE;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 4'd0;
      end
    endcase
  end

  // Clear beats a same-edge event; the FSM keeps running so a held level is not recounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count    <= '0;
      evt_pulse    <= 1'b0;
      sat          <= 1'b0;
      rpt.rpt_val  <= 1'b0;
      rpt.rpt_data <= '0;
    end else if (clear) begin
      evt_count   <= '0;
      evt_pulse   <= 1'b0;
      sat         <= 1'b0;
      rpt.rpt_val <= 1'b0;
    end else begin
      evt_pulse <= evt;
      if (evt) begin
        evt_count    <= cnt_nxt;
        rpt.rpt_data <= cnt_nxt;
        rpt.rpt_val  <= 1'b1;
        if (sat_set) sat <= 1'b1;
      end else if (rpt.rpt_val && rpt.rpt_rdy) begin
        rpt.rpt_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_majority_event_counter.sv
// Self-checking bench for majority_event_counter.
// Run-length reference model; honours MAJ_EVT_WRAP_EN.
module tb_majority_event_counter;

  localparam int CNT_W    = 8;
  localparam int MIN_HOLD = 2;
  localparam int MAXV     = (1 << CNT_W) - 1;
  localparam int EV       = 1 + MIN_HOLD;
`ifdef MAJ_EVT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             det_in;
  logic             clear;
  logic [CNT_W-1:0] evt_count;
  logic             evt_pulse;
  logic             sat;

  majority_event_counter_if #(.CNT_W(CNT_W)) rpt ();

  majority_event_counter #(
    .CNT_W   (CNT_W),
    .MIN_HOLD(MIN_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .det_in   (det_in),
    .clear    (clear),
    .evt_count(evt_count),
    .evt_pulse(evt_pulse),
    .sat      (sat),
    .rpt      (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model: an event is the edge at which the run of high samples first reaches MIN_HOLD.
  int run_m  = 0;
  int m_cnt  = 0;
  int m_data = 0;
  bit m_val  = 0;
  bit m_pls  = 0;
  bit m_sat  = 0;

  task automatic model_reset();
    run_m  = 0;
    m_cnt  = 0;
    m_data = 0;
    m_val  = 0;
    m_pls  = 0;
    m_sat  = 0;
  endtask

  task automatic tick();
    bit ev;
    ev = (run_m == MIN_HOLD);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (clear) begin
        m_cnt = 0;
        m_sat = 0;
        m_val = 0;
        m_pls = 0;
      end else begin
        m_pls = ev;
        if (ev) begin
          if (m_cnt == MAXV) begin
            if (WRAP) m_cnt = 0;
            else m_sat = 1;
          end else begin
            m_cnt = m_cnt + 1;
          end
          m_data = m_cnt;
          m_val  = 1;
        end else if (m_val && rpt.rpt_rdy) begin
          m_val = 0;
        end
      end
      if (!det_in) run_m = 0;
      else if (run_m <= MIN_HOLD) run_m = run_m + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    det_in = 0;
    clear = 0;
    rpt.rpt_rdy = 0;
    tick();
    tick();
    nchk++;
    if ({evt_count, evt_pulse, sat} !== '0) begin
      nerr++;
      $display("FAIL reset_out cnt=%0d pls=%b sat=%b want 0",
               evt_count, evt_pulse, sat);
    end
    nchk++;
    if ({rpt.rpt_val, rpt.rpt_data} !== '0) begin
      nerr++;
      $display("FAIL reset_rpt val=%b data=%0d want 0",
               rpt.rpt_val, rpt.rpt_data);
    end
    rst_n = 1;
  endtask

  task automatic test_single_event();
    det_in = 1;
    rpt.rpt_rdy = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      nchk++;
      if (evt_count !== CNT_W'(i >= EV ? 1 : 0)) begin
        nerr++;
        $display("FAIL single_cnt edge=%0d got=%0d", i, evt_count);
      end
      nchk++;
      if (evt_pulse !== (i == EV)) begin
        nerr++;
        $display("FAIL single_pulse edge=%0d got=%b", i, evt_pulse);
      end
      nchk++;
      if (rpt.rpt_val !== (i >= EV) ||
          rpt.rpt_data !== CNT_W'(i >= EV ? 1 : 0)) begin
        nerr++;
        $display("FAIL single_rpt edge=%0d val=%b data=%0d",
                 i, rpt.rpt_val, rpt.rpt_data);
      end
    end
    rpt.rpt_rdy = 1;
    tick();
    nchk++;
    if (rpt.rpt_val !== 1'b0 || evt_count !== CNT_W'(1)) begin
      nerr++;
      $display("FAIL single_xfer val=%b cnt=%0d want 0/1",
               rpt.rpt_val, evt_count);
    end
    det_in = 0;
    rpt.rpt_rdy = 0;
    tick();
  endtask

  task automatic test_glitch();
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 10; i++) begin
      det_in = 1;
      tick();
      det_in = 0;
      tick();
      nchk++;
      if (evt_count !== '0 || evt_pulse !== 1'b0 ||
          rpt.rpt_val !== 1'b0) begin
        nerr++;
        $display("FAIL glitch i=%0d cnt=%0d pls=%b val=%b want 0",
                 i, evt_count, evt_pulse, rpt.rpt_val);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    rpt.rpt_rdy = 0;
    for (int e = 0; e < 3; e++) begin
      det_in = 1;
      repeat (MIN_HOLD) tick();
      det_in = 0;
      tick();
    end
    repeat (3) tick();
    nchk++;
    if (rpt.rpt_val !== 1'b1 || rpt.rpt_data !== CNT_W'(3)) begin
      nerr++;
      $display("FAIL bp_hold val=%b data=%0d want 1/3",
               rpt.rpt_val, rpt.rpt_data);
    end
    nchk++;
    if (evt_count !== CNT_W'(3)) begin
      nerr++;
      $display("FAIL bp_cnt got=%0d want 3", evt_count);
    end
    rpt.rpt_rdy = 1;
    tick();
    nchk++;
    if (rpt.rpt_val !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drop val=%b want 0", rpt.rpt_val);
    end
    tick();
    nchk++;
    if (rpt.rpt_val !== 1'b0) begin
      nerr++;
      $display("FAIL bp_single val=%b want 0", rpt.rpt_val);
    end
    rpt.rpt_rdy = 0;
  endtask

  task automatic test_clear_collision();
    det_in = 1;
    repeat (MIN_HOLD) tick();
    clear = 1;
    tick();
    clear = 0;
    nchk++;
    if (evt_count !== '0 || evt_pulse !== 1'b0 ||
        rpt.rpt_val !== 1'b0) begin
      nerr++;
      $display("FAIL clr_edge cnt=%0d pls=%b val=%b want 0",
               evt_count, evt_pulse, rpt.rpt_val);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++;
      if (evt_count !== '0 || evt_pulse !== 1'b0 ||
          rpt.rpt_val !== 1'b0) begin
        nerr++;
        $display("FAIL clr_held i=%0d cnt=%0d pls=%b val=%b",
                 i, evt_count, evt_pulse, rpt.rpt_val);
      end
    end
    det_in = 0;
    tick();
  endtask

  task automatic test_saturate();
    clear = 1;
    tick();
    clear = 0;
    rpt.rpt_rdy = 1;
    for (int e = 0; e < MAXV; e++) begin
      det_in = 1;
      repeat (MIN_HOLD) tick();
      det_in = 0;
      tick();
    end
    nchk++;
    if (evt_count !== CNT_W'(MAXV) || sat !== 1'b0) begin
      nerr++;
      $display("FAIL sat_pre cnt=%0d sat=%b want %0d/0",
               evt_count, sat, MAXV);
    end
    rpt.rpt_rdy = 0;
    det_in = 1;
    repeat (MIN_HOLD) tick();
    det_in = 0;
    tick();
    nchk++;
    if (evt_count !== CNT_W'(WRAP ? 0 : MAXV) || sat !== !WRAP) begin
      nerr++;
      $display("FAIL sat_over cnt=%0d sat=%b", evt_count, sat);
    end
    nchk++;
    if (evt_pulse !== 1'b1 || rpt.rpt_val !== 1'b1 ||
        rpt.rpt_data !== CNT_W'(WRAP ? 0 : MAXV)) begin
      nerr++;
      $display("FAIL sat_rpt pls=%b val=%b data=%0d",
               evt_pulse, rpt.rpt_val, rpt.rpt_data);
    end
    clear = 1;
    tick();
    clear = 0;
    nchk++;
    if (evt_count !== '0 || sat !== 1'b0 || rpt.rpt_val !== 1'b0) begin
      nerr++;
      $display("FAIL sat_clr cnt=%0d sat=%b val=%b want 0",
               evt_count, sat, rpt.rpt_val);
    end
  endtask

  task automatic test_async_reset();
    rpt.rpt_rdy = 0;
    det_in = 1;
    repeat (MIN_HOLD) tick();
    det_in = 0;
    tick();
    det_in = 1;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    nchk++;
    if ({evt_count, evt_pulse, sat, rpt.rpt_val, rpt.rpt_data} !== '0) begin
      nerr++;
      $display("FAIL arst_out cnt=%0d pls=%b sat=%b val=%b data=%0d",
               evt_count, evt_pulse, sat, rpt.rpt_val, rpt.rpt_data);
    end
    #1;
    rst_n = 1;
    for (int k = 1; k <= EV; k++) begin
      tick();
      nchk++;
      if (evt_count !== CNT_W'(k == EV ? 1 : 0) ||
          rpt.rpt_val !== (k == EV)) begin
        nerr++;
        $display("FAIL arst_requal edge=%0d cnt=%0d val=%b",
                 k, evt_count, rpt.rpt_val);
      end
    end
    det_in = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      det_in = ($urandom_range(0, 99) < 60);
      rpt.rpt_rdy = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 29) == 0);
      tick();
      nchk++;
      if (evt_count !== CNT_W'(m_cnt) || evt_pulse !== m_pls ||
          sat !== m_sat) begin
        nerr++;
        $display("FAIL rnd_cnt i=%0d cnt=%0d/%0d pls=%b/%b sat=%b/%b",
                 i, evt_count, m_cnt, evt_pulse, m_pls, sat, m_sat);
      end
      nchk++;
      if (rpt.rpt_val !== m_val ||
          (m_val && rpt.rpt_data !== CNT_W'(m_data))) begin
        nerr++;
        $display("FAIL rnd_rpt i=%0d val=%b/%b data=%0d/%0d",
                 i, rpt.rpt_val, m_val, rpt.rpt_data, m_data);
      end
    end
    clear = 0;
    det_in = 0;
    rpt.rpt_rdy = 0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_glitch();
    test_backpressure();
    test_clear_collision();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
